acc_write_arbiter: RTL and testbench
====================================

ACC_WRITE_ARBITER -- requirements
Module: acc_write_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing the accumulator write port.
REQ-002 Parameter DW, default 8, accumulator data width.
REQ-003 Parameter AW, default 2, accumulator address width (4 entries).
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-006 req  input  NREQ  per-requester write request.
REQ-007 lock  input  NREQ  per-requester burst lock: keep the grant after this transfer.
REQ-008 req_adr  input  NREQ x AW  per-requester target entry.
REQ-009 req_data  input  NREQ x DW  per-requester write data.
REQ-010 gnt  output  NREQ  one-hot-or-zero grant, combinational from state and req.
REQ-011 AcWen  output  1  registered write enable to the accumulator file.
REQ-012 WrAdr  output  AW  registered write address.
REQ-013 WrData  output  DW  registered write data.
REQ-014 locked  output  1  high while the FSM is in LOCKED.
REQ-015 owner  output  clog2(NREQ)  index of the current lock owner; 0 when not locked.

Function
REQ-016 Transfer occurs in a cycle where req[i] & gnt[i]; at most one transfer per cycle.
REQ-017 On transfer by i, the next posedge SHALL set AcWen=1, WrAdr=req_adr[i], WrData=req_data[i]; no transfer: AcWen=0, WrAdr/WrData hold (latency exactly 1 cycle).
REQ-018 FSM states ARB and LOCKED; reset state ARB.
REQ-019 ARB: gnt goes to the first requester with req=1, searching from rr_ptr upward modulo NREQ; gnt=0 if no req.
REQ-020 After a transfer by i in ARB, rr_ptr <= (i+1) mod NREQ; rr_ptr is unchanged with no transfer.
REQ-021 ARB -> LOCKED when the transferring requester i has lock[i]=1; owner <= i.
REQ-022 LOCKED: gnt[owner]=req[owner]; all other gnt bits 0 regardless of req.
REQ-023 LOCKED -> ARB when the owner transfers with lock[owner]=0, or when req[owner]=0 (lock dropped without transfer); rr_ptr <= (owner+1) mod NREQ on exit.
REQ-024 LOCKED persists while the owner transfers with lock[owner]=1; no cycle limit.
REQ-025 lock[i] is ignored unless requester i transfers in that cycle.
REQ-026 rr_ptr wraps NREQ-1 -> 0.
REQ-027 gnt SHALL never be non-zero for a requester whose req=0.
REQ-028 Requester data/address need only be valid in the transfer cycle; the block captures them.

Reset
REQ-029 While rst=0, immediately: state=ARB, rr_ptr=0, owner=0, AcWen=0, WrAdr=0, WrData=0; gnt=0 and locked=0.
REQ-030 Reset asserted mid-burst or in the cycle after a transfer SHALL cancel the pending write (AcWen=0); no write reaches the accumulator.
REQ-031 First arbitration after rst deasserts SHALL start from requester 0.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef (ARB, LOCKED) and the default DW/AW/NREQ constants shared with the accumulator file.
REQ-033 One sub-module, rr_pick, SHALL implement the combinational round-robin search (req, rr_ptr -> one-hot grant, index, valid).

Verification
REQ-034 Reset then req=3'b111, no lock, for 4 cycles -> grants 0,1,2,0; AcWen=1 each following cycle with the matching req_adr/req_data.
REQ-035 Req[1] alone with req_adr=2, req_data=8'hA5 -> gnt=3'b010 same cycle; next cycle AcWen=1, WrAdr=2, WrData=8'hA5; following cycle AcWen=0.
REQ-036 Req[0] with lock=1 for 3 transfers while req[2]=1 -> gnt[2]=0 throughout, locked=1, owner=0; on the 3rd transfer lock=0 -> next cycle ARB, gnt=3'b100.
REQ-037 Owner in LOCKED drops req -> same-cycle gnt=0, next cycle locked=0 and rr_ptr=owner+1.
REQ-038 rst driven low in the cycle after a transfer of 8'h3C -> AcWen=0 immediately, WrData=0, state ARB, rr_ptr=0.
REQ-039 rr_ptr=2, req=3'b101 -> gnt=3'b100; next cycle with req=3'b101 -> gnt=3'b001 (wrap-around).

Source files
------------

// File: rtl/acc_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the accumulator write-port arbiter.
// The accumulator register file uses the same default widths.
package acc_write_arbiter_pkg;

  localparam int ACC_NREQ = 3;
  localparam int ACC_DW   = 8;
  localparam int ACC_AW   = 2;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ARB    = 1'b0;
  localparam arb_state_t LOCKED = 1'b1;

  // Index width that stays legal when there is only a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_write_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr, modulo NREQ.
module rr_pick
  import acc_write_arbiter_pkg::*;
#(
  parameter int NREQ = ACC_NREQ,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_write_arbiter.sv
// Round-robin arbiter with burst lock for the shared accumulator write port.
// The winning request is registered into a one-cycle-latency write strobe.
module acc_write_arbiter
  import acc_write_arbiter_pkg::*;
#(
  parameter int NREQ = ACC_NREQ,
  parameter int DW   = ACC_DW,
  parameter int AW   = ACC_AW,
  localparam int IW  = idx_width(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           lock,
  input  logic [NREQ-1:0][AW-1:0]   req_adr,
  input  logic [NREQ-1:0][DW-1:0]   req_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      AcWen,
  output logic [AW-1:0]             WrAdr,
  output logic [DW-1:0]             WrData,
  output logic                      locked,
  output logic [IW-1:0]             owner
);

  arb_state_t      state;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [NREQ-1:0] owner_gnt;
  logic [IW-1:0]   xfer_idx;
  logic            xfer;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Grant is masked by reset so nothing is granted while rst is held low.
  always_comb begin
    owner_gnt        = '0;
    owner_gnt[owner] = req[owner];
    gnt              = '0;
    if (rst) begin
      gnt = (state == LOCKED) ? owner_gnt : pick_gnt;
    end
  end

  assign xfer_idx = (state == LOCKED) ? owner : pick_idx;
  assign xfer     = |(req & gnt);
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ARB;
      rr_ptr <= '0;
      owner  <= '0;
      AcWen  <= 1'b0;
      WrAdr  <= '0;
      WrData <= '0;
    end else begin
      AcWen <= xfer;
      if (xfer) begin
        WrAdr  <= req_adr[xfer_idx];
        WrData <= req_data[xfer_idx];
      end
      if (state == ARB) begin
        if (xfer) begin
          rr_ptr <= wrap_inc(xfer_idx);
          if (lock[xfer_idx]) begin
            state <= LOCKED;
            owner <= xfer_idx;
          end
        end
      end else begin
        // Leave the burst when the owner releases lock on a transfer or stops requesting.
        if (!req[owner] || (xfer && !lock[owner])) begin
          state  <= ARB;
          owner  <= '0;
          rr_ptr <= wrap_inc(owner);
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_write_arbiter.sv
// Directed self-checking bench for acc_write_arbiter with hand-computed expectations.
module tb_acc_write_arbiter;

  logic                clk;
  logic                rst;
  logic [2:0]          req;
  logic [2:0]          lock;
  logic [2:0][1:0]     req_adr;
  logic [2:0][7:0]     req_data;
  logic [2:0]          gnt;
  logic                AcWen;
  logic [1:0]          WrAdr;
  logic [7:0]          WrData;
  logic                locked;
  logic [1:0]          owner;

  int compared   = 0;
  int mismatched = 0;

  acc_write_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .lock     (lock),
    .req_adr  (req_adr),
    .req_data (req_data),
    .gnt      (gnt),
    .AcWen    (AcWen),
    .WrAdr    (WrAdr),
    .WrData   (WrData),
    .locked   (locked),
    .owner    (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] l);
    req  = r;
    lock = l;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    lock     = '0;
    req_adr  = '0;
    req_data = '0;
    req_adr[0] = 2'd1; req_data[0] = 8'h10;
    req_adr[1] = 2'd2; req_data[1] = 8'h21;
    req_adr[2] = 2'd3; req_data[2] = 8'h32;

    // Asynchronous reset takes effect before any clock edge
    #2 rst = 1'b0;
    applyStimulus(3'b111, 3'b000);
    checkOutput("rst_gnt",    gnt,    0);
    checkOutput("rst_acwen",  AcWen,  0);
    checkOutput("rst_wradr",  WrAdr,  0);
    checkOutput("rst_wrdata", WrData, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_owner",  owner,  0);
    tick();

    // Plain round robin across all three requesters
    rst = 1'b1;
    applyStimulus(3'b111, 3'b000);
    checkOutput("rr_gnt0", gnt, 3'b001);
    tick();
    checkOutput("rr_w0_en",   AcWen,  1);
    checkOutput("rr_w0_adr",  WrAdr,  1);
    checkOutput("rr_w0_data", WrData, 8'h10);
    checkOutput("rr_gnt1",    gnt,    3'b010);
    tick();
    checkOutput("rr_w1_en",   AcWen,  1);
    checkOutput("rr_w1_adr",  WrAdr,  2);
    checkOutput("rr_w1_data", WrData, 8'h21);
    checkOutput("rr_gnt2",    gnt,    3'b100);
    tick();
    checkOutput("rr_w2_adr",  WrAdr,  3);
    checkOutput("rr_w2_data", WrData, 8'h32);
    checkOutput("rr_gnt0b",   gnt,    3'b001);
    tick();
    checkOutput("rr_w3_en",   AcWen,  1);
    checkOutput("rr_w3_data", WrData, 8'h10);

    // Single requester 1, one-cycle write latency then idle with held data
    req_adr[1] = 2'd2; req_data[1] = 8'hA5;
    applyStimulus(3'b010, 3'b000);
    checkOutput("single_gnt", gnt, 3'b010);
    tick();
    checkOutput("single_en",   AcWen,  1);
    checkOutput("single_adr",  WrAdr,  2);
    checkOutput("single_data", WrData, 8'hA5);
    applyStimulus(3'b000, 3'b000);
    checkOutput("idle_gnt", gnt, 0);
    tick();
    checkOutput("idle_en",   AcWen,  0);
    checkOutput("idle_adr",  WrAdr,  2);
    checkOutput("idle_data", WrData, 8'hA5);

    // Pointer at 2 wraps to requester 0
    checkOutput("wrap_ptr", dut.rr_ptr, 2);
    applyStimulus(3'b101, 3'b000);
    checkOutput("wrap_gnt2", gnt, 3'b100);
    tick();
    checkOutput("wrap_gnt0", gnt, 3'b001);
    checkOutput("wrap_data", WrData, 8'h32);
    applyStimulus(3'b000, 3'b000);
    tick();
    checkOutput("wrap_idle_en", AcWen, 0);

    // Requester 0 locks for three transfers while requester 2 waits
    applyStimulus(3'b101, 3'b001);
    checkOutput("lk_gnt_a", gnt, 3'b001);
    tick();
    checkOutput("lk_locked_a", locked, 1);
    checkOutput("lk_owner_a",  owner,  0);
    checkOutput("lk_gnt_b",    gnt,    3'b001);
    checkOutput("lk_data_a",   WrData, 8'h10);
    req_data[0] = 8'h11;
    tick();
    checkOutput("lk_locked_b", locked, 1);
    checkOutput("lk_gnt_c",    gnt,    3'b001);
    checkOutput("lk_data_b",   WrData, 8'h11);
    req_data[0] = 8'h12;
    applyStimulus(3'b101, 3'b000);
    checkOutput("lk_gnt_last", gnt, 3'b001);
    tick();
    checkOutput("lk_exit_locked", locked, 0);
    checkOutput("lk_exit_owner",  owner,  0);
    checkOutput("lk_exit_gnt",    gnt,    3'b100);
    checkOutput("lk_exit_data",   WrData, 8'h12);
    checkOutput("lk_exit_ptr",    dut.rr_ptr, 1);

    // Requester 2 locks, then drops its request without transferring
    applyStimulus(3'b101, 3'b100);
    tick();
    checkOutput("drop_locked", locked, 1);
    checkOutput("drop_owner",  owner,  2);
    applyStimulus(3'b001, 3'b000);
    checkOutput("drop_gnt", gnt, 0);
    tick();
    checkOutput("drop_unlocked", locked, 0);
    checkOutput("drop_ptr",      dut.rr_ptr, 0);
    checkOutput("drop_en",       AcWen, 0);
    checkOutput("drop_gnt_arb",  gnt, 3'b001);

    // Reset in the cycle after a transfer cancels the pending write
    req_data[0] = 8'h3C;
    applyStimulus(3'b001, 3'b000);
    tick();
    checkOutput("pre_rst_data", WrData, 8'h3C);
    checkOutput("pre_rst_ptr",  dut.rr_ptr, 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_en",    AcWen, 0);
    checkOutput("mid_rst_data",  WrData, 0);
    checkOutput("mid_rst_state", dut.state, 0);
    checkOutput("mid_rst_ptr",   dut.rr_ptr, 0);
    checkOutput("mid_rst_gnt",   gnt, 0);
    tick();
    checkOutput("mid_rst_en_hold", AcWen, 0);

    // First arbitration after reset starts at requester 0
    rst = 1'b1;
    applyStimulus(3'b111, 3'b000);
    checkOutput("post_rst_gnt", gnt, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
